serial_adder: RTL and testbench

- Parametrised multi-cycle adder, successor to the single-bit clocked full_adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB first.
- Uses valid/ready handshakes on input and output.
- Sits between operand producers and result consumers where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/digit_adder.sv | 28 ++
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial_adder block.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Width of the digit counter; at least one bit even when N == 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple adder of DIGIT full-adder cells; also exposes the carry into the top bit.
module digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [DIGIT:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int i = 0; i < DIGIT; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
        end
    end

    assign cout_o = c[DIGIT];
    assign cmsb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (A - B - borrow_in).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = cnt_width(N);

    state_e           state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             load;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout, dig_cmsb;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + ~borrow_in; inversion happens once at capture.
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? ~cin : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_i   (a_q[DIGIT-1:0]),
        .b_i   (b_q[DIGIT-1:0]),
        .cin_i (carry_q),
        .sum_o (dig_sum),
        .cout_o(dig_cout),
        .cmsb_o(dig_cmsb)
    );

    assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = in_valid;
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
                carry_d = dig_cout;
                count_d = count_q + 1'b1;
                if (count_q == CntW'(N - 1)) begin
                    state_d = StDone;
                    count_d = '0;
                    sum_d   = res_d;
                    cout_d  = dig_cout;
                    ovf_d   = dig_cout ^ dig_cmsb;
                end
            end
            StDone: begin
                if (out_ready) begin
                    load    = in_valid;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d = StRun;
            count_d = '0;
            a_d     = a;
            b_d     = b_in;
            carry_d = c_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: DIGIT=1 and DIGIT=4 instances, hand-computed vectors.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_valid4, out_ready, out_ready4;
    logic [7:0] a, b;
    logic       cin;
    logic       sub;
    logic       in_ready, out_valid, cout, overflow;
    logic [7:0] sum;
    logic       in_ready4, out_valid4, cout4, overflow4;
    logic [7:0] sum4;

    int tests = 0;
    int fails = 0;
    int cyc;
    int seen;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid4),
        .in_ready (in_ready4),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid4),
        .out_ready(out_ready4),
        .sum      (sum4),
        .cout     (cout4),
        .overflow (overflow4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for out_valid of the DIGIT=1 instance; returns edges taken.
    task automatic wait_valid1(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic accept1(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_valid4  = 1'b0;
        out_ready  = 1'b0;
        out_ready4 = 1'b1;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // 0x3C + 0x55 = 0x91, signed overflow
        accept1(8'h3C, 8'h55, 1'b0);
        check("run_in_ready", in_ready, 0);
        wait_valid1(cyc);
        check("t1_latency", cyc, 8);
        check("t1_sum", sum, 8'h91);
        check("t1_cout", cout, 0);
        check("t1_ovf", overflow, 1);
        out_ready = 1'b1;
        tick();
        check("t1_idle_valid", out_valid, 0);
        check("t1_idle_ready", in_ready, 1);
        check("t1_hold_sum", sum, 8'h91);

        // 0xFF + 0x01 with consumer stalled for 5 cycles
        out_ready = 1'b0;
        accept1(8'hFF, 8'h01, 1'b0);
        wait_valid1(cyc);
        check("t2_latency", cyc, 8);
        check("t2_sum", sum, 8'h00);
        check("t2_cout", cout, 1);
        check("t2_ovf", overflow, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_valid", out_valid, 1);
            check("t2_stall_sum", sum, 8'h00);
            check("t2_stall_cout", cout, 1);
            check("t2_stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("t2_in_ready_comb", in_ready, 1);
        tick();
        check("t2_idle", out_valid, 0);

        // Back-to-back: second operands held during RUN must be ignored until DONE
        a        = 8'h01;
        b        = 8'h02;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        a = 8'h10;
        b = 8'h20;
        wait_valid1(cyc);
        check("b2b_first_latency", cyc, 8);
        check("b2b_first_sum", sum, 8'h03);
        check("b2b_done_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        cyc      = 1;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b_second_gap", cyc, 9);
        check("b2b_second_sum", sum, 8'h30);
        tick();
        check("b2b_idle", out_valid, 0);

        // Reset at count=3 of a RUN discards the operation
        accept1(8'h12, 8'h34, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_no_stale", seen, 0);

        // DIGIT=4: 0x7F + 0x01 + 1 = 0x81
        a         = 8'h7F;
        b         = 8'h01;
        cin       = 1'b1;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        cyc       = 0;
        while (!out_valid4 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("d4_latency", cyc, 2);
        check("d4_sum", sum4, 8'h81);
        check("d4_cout", cout4, 0);
        check("d4_ovf", overflow4, 1);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        accept1(8'h10, 8'h01, 1'b0);
        wait_valid1(cyc);
        check("sub1_sum", sum, 8'h0F);
        check("sub1_cout", cout, 1);
        tick();
        accept1(8'h00, 8'h01, 1'b0);
        wait_valid1(cyc);
        check("sub2_sum", sum, 8'hFF);
        check("sub2_cout", cout, 0);
        check("sub2_ovf", overflow, 0);
        tick();
        sub = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
